// File: rtl/alu_seq_ctrl_pkg.sv
// alu_pkg: shared widths, opcode set, button bit map and FSM state codes
// for the ALU load sequencer.
package alu_pkg;

    localparam int NB_DATA_DEF = 6;
    localparam int NB_OP_DEF   = 6;
    localparam int NB_BTN_DEF  = 3;

    // Button bit positions inside the button vector
    localparam int BTN_A  = 2;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 0;

    // Opcodes understood by the ALU datapath
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HAVE_A = 3'd1;
    localparam logic [2:0] ST_HAVE_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_SHOW   = 3'd4;

    // Opcode legality; the caller zero-extends to 32 bits so any opcode
    // width compares exactly (stray high bits make it illegal).
    function automatic logic op_is_legal(input logic [31:0] op);
        return (op == 32'(OP_ADD)) || (op == 32'(OP_SUB)) ||
               (op == 32'(OP_AND)) || (op == 32'(OP_OR))  ||
               (op == 32'(OP_XOR)) || (op == 32'(OP_NOR)) ||
               (op == 32'(OP_SRA)) || (op == 32'(OP_SRL));
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: switch/button inputs, ALU result and the registered
// operand/LED outputs of the sequencer. slave = sequencer side.
interface alu_seq_ctrl_if
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int NB_BTN  = NB_BTN_DEF
);
    logic [NB_DATA-1:0] i_SWs;
    logic [NB_BTN-1:0]  i_buttons;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_led;
    logic               o_valid;
    logic               o_busy;
    logic               o_err;

    modport slave (
        input  i_SWs, i_buttons, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_led, o_valid, o_busy, o_err
    );

    modport master (
        output i_SWs, i_buttons, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_led, o_valid, o_busy, o_err
    );
endinterface

// File: rtl/alu_seq_ctrl_btn_edge_sync.sv
// btn_edge_sync: 2-FF synchroniser per raw button plus a previous-value
// flop; emits a one-cycle pulse on each synchronised rising edge, so a held
// button yields exactly one pulse.
module btn_edge_sync #(
    parameter int NB_BTN = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_pulse
);
    logic [NB_BTN-1:0] sync1, sync2, prev;

    // Metastability chain and edge-history flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign o_pulse = sync2 & ~prev;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: button-driven A -> B -> OP load sequencer in front of the
// combinational ALU. Result is captured one edge after the opcode load and
// held on the LEDs. Optional macro ALU_OPCHECK_EN rejects unknown opcodes.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int NB_BTN  = NB_BTN_DEF
) (
    input  logic          clock,
    input  logic          reset,
    alu_seq_ctrl_if.slave bus
);
    logic [NB_BTN-1:0]  pulse;
    logic               p_a, p_b, p_op, p_multi, op_legal;
    logic [NB_OP-1:0]   sw_op;
    logic [2:0]         state;
    logic [NB_DATA-1:0] a_q, b_q, led_q;
    logic [NB_OP-1:0]   op_q;
    logic               valid_q, err_q;

    btn_edge_sync #(.NB_BTN(NB_BTN)) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (bus.i_buttons),
        .o_pulse (pulse)
    );

    assign p_a     = pulse[BTN_A];
    assign p_b     = pulse[BTN_B];
    assign p_op    = pulse[BTN_OP];
    // More than one bit set: clearing the lowest set bit leaves something
    assign p_multi = |(pulse & (pulse - NB_BTN'(1)));

    // Opcode comes from the low switch bits, zero-extended if wider
    generate
        if (NB_OP <= NB_DATA) begin : g_op_trunc
            assign sw_op = bus.i_SWs[NB_OP-1:0];
        end else begin : g_op_zext
            assign sw_op = {{(NB_OP-NB_DATA){1'b0}}, bus.i_SWs};
        end
    endgenerate

`ifdef ALU_OPCHECK_EN
    assign op_legal = op_is_legal(32'(sw_op));
`else
    assign op_legal = 1'b1;
`endif

    // Load sequencer: operand/opcode registers, result capture and flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == ST_EXEC) begin
            // Single execute cycle; any pulse here is dropped silently
            led_q   <= bus.i_alu_result;
            valid_q <= 1'b1;
            state   <= ST_SHOW;
        end else if (p_multi) begin
            err_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p_a) begin
                        a_q   <= bus.i_SWs;
                        state <= ST_HAVE_A;
                    end else if (p_b || p_op) begin
                        err_q <= 1'b1;
                    end
                end
                ST_HAVE_A: begin
                    if (p_a) begin
                        a_q <= bus.i_SWs;
                    end else if (p_b) begin
                        b_q   <= bus.i_SWs;
                        state <= ST_HAVE_B;
                    end else if (p_op) begin
                        err_q <= 1'b1;
                    end
                end
                ST_HAVE_B: begin
                    if (p_a) begin
                        a_q   <= bus.i_SWs;
                        state <= ST_HAVE_A;
                    end else if (p_b) begin
                        b_q <= bus.i_SWs;
                    end else if (p_op) begin
                        if (op_legal) begin
                            op_q  <= sw_op;
                            state <= ST_EXEC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    // Any accepted load invalidates the shown result
                    if (p_a) begin
                        a_q     <= bus.i_SWs;
                        valid_q <= 1'b0;
                        state   <= ST_HAVE_A;
                    end else if (p_b) begin
                        b_q     <= bus.i_SWs;
                        valid_q <= 1'b0;
                        state   <= ST_EXEC;
                    end else if (p_op) begin
                        if (op_legal) begin
                            op_q    <= sw_op;
                            valid_q <= 1'b0;
                            state   <= ST_EXEC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_alu_a  = a_q;
    assign bus.o_alu_b  = b_q;
    assign bus.o_alu_op = op_q;
    assign bus.o_led    = led_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_busy   = (state == ST_EXEC);
    assign bus.o_err    = err_q;
endmodule
